// File: rtl/vga_pkg.sv
// Shared 1024x768 VGA pipeline definitions: timing totals, palette,
// the pixel bundle passed between stages and the bar colour map.
package vga_pkg;
  localparam int H_TOTAL  = 1344;
  localparam int V_TOTAL  = 806;
  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;

  localparam logic [11:0] BLACK  = 12'h000;
  localparam logic [11:0] RED    = 12'hf00;
  localparam logic [11:0] YELLOW = 12'hff0;
  localparam logic [11:0] GREEN  = 12'h0f0;

  localparam int N_CH = 13;

  typedef struct packed {
    logic [11:0] vcount;
    logic [11:0] hcount;
    logic        vsync;
    logic        vblnk;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_t;

  function automatic logic [11:0] bar_colour(input logic [11:0] v);
    logic [11:0] c;
    if (v >= 12'd3072)      c = RED;
    else if (v >= 12'd2048) c = YELLOW;
    else                    c = GREEN;
    return c;
  endfunction
endpackage

// File: rtl/draw_bars_if.sv
// Pixel stream in/out of the bar overlay plus the channel-load port.
interface draw_bars_if;
  import vga_pkg::*;
  logic [11:0]         vcount_in, hcount_in;
  logic                vsync_in, vblnk_in, hsync_in, hblnk_in;
  logic [11:0]         rgb_in;
  logic [N_CH*12-1:0]  ch_data_in;
  logic                ch_valid_in;
  logic [11:0]         vcount_out, hcount_out;
  logic                vsync_out, vblnk_out, hsync_out, hblnk_out;
  logic [11:0]         rgb_out;
  logic                upd_out;

  modport master (
    output vcount_in, hcount_in, vsync_in, vblnk_in, hsync_in, hblnk_in,
           rgb_in, ch_data_in, ch_valid_in,
    input  vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out,
           rgb_out, upd_out
  );
  modport slave (
    input  vcount_in, hcount_in, vsync_in, vblnk_in, hsync_in, hblnk_in,
           rgb_in, ch_data_in, ch_valid_in,
    output vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out,
           rgb_out, upd_out
  );
endinterface

// File: rtl/draw_bars_hit.sv
// Column decode: which bar (if any) covers hcount. Bar edges are
// elaboration-time constants, so this is just N_CH range compares.
module draw_bars_hit
  import vga_pkg::*;
#(
  parameter int X0        = 24,
  parameter int BAR_W     = 64,
  parameter int BAR_PITCH = 76
) (
  input  logic [11:0] hcount,
  output logic        in_col,
  output logic [3:0]  ch_idx
);
  logic [N_CH-1:0] match;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam logic [11:0] LEFT  = 12'(X0 + i*BAR_PITCH);
    localparam logic [11:0] RIGHT = 12'(X0 + i*BAR_PITCH + BAR_W - 1);
    assign match[i] = (hcount >= LEFT) && (hcount <= RIGHT);
  end

  // Bars never overlap, so at most one bit of match is set.
  always_comb begin
    in_col = |match;
    ch_idx = '0;
    for (int i = 0; i < N_CH; i++)
      if (match[i]) ch_idx = 4'(i);
  end
endmodule

// File: rtl/draw_bars.sv
// 13-channel bar graph overlay, 2-stage pipeline. Channel data is
// double-buffered and swapped on the vblnk rising edge at the input.
module draw_bars
  import vga_pkg::*;
#(
  parameter int X0        = 24,
  parameter int BAR_W     = 64,
  parameter int BAR_PITCH = 76,
  parameter int BASE_Y    = 700
) (
  input  logic        pclk,
  input  logic        rst,
  draw_bars_if.slave  bus
);
  logic [N_CH-1:0][11:0] pending, active;
  logic                  vblnk_prev, swap;

  logic                  hit_col;
  logic [3:0]            hit_idx;

  vga_t                  s1;
  logic                  in_col_s1;
  logic [11:0]           val_s1;

  logic [8:0]            height;
  logic [11:0]           top_y;
  logic                  hit, blank;

  assign swap = bus.vblnk_in & ~vblnk_prev;

  // Swap reads pending before this cycle's load, so a coincident load waits a frame.
  always_ff @(posedge pclk) begin
    if (rst) begin
      pending     <= '0;
      active      <= '0;
      vblnk_prev  <= 1'b0;
      bus.upd_out <= 1'b0;
    end else begin
      vblnk_prev  <= bus.vblnk_in;
      if (bus.ch_valid_in) pending <= bus.ch_data_in;
      if (swap)            active  <= pending;
      bus.upd_out <= swap;
    end
  end

  draw_bars_hit #(.X0(X0), .BAR_W(BAR_W), .BAR_PITCH(BAR_PITCH)) u_hit (
    .hcount (bus.hcount_in),
    .in_col (hit_col),
    .ch_idx (hit_idx)
  );

  always_ff @(posedge pclk) begin
    if (rst) begin
      s1        <= '0;
      in_col_s1 <= 1'b0;
      val_s1    <= '0;
    end else begin
      s1        <= '{vcount: bus.vcount_in, hcount: bus.hcount_in,
                     vsync: bus.vsync_in, vblnk: bus.vblnk_in,
                     hsync: bus.hsync_in, hblnk: bus.hblnk_in, rgb: bus.rgb_in};
      in_col_s1 <= hit_col;
      val_s1    <= hit_col ? active[hit_idx] : 12'd0;
    end
  end

  // Height 0 makes top_y = BASE_Y+1, so the row range is empty on its own.
  always_comb begin
    height = val_s1[11:3];
    top_y  = 12'(BASE_Y) - {3'b000, height} + 12'd1;
    blank  = s1.hblnk | s1.vblnk;
    hit    = in_col_s1 && (s1.vcount <= 12'(BASE_Y)) && (s1.vcount >= top_y);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      bus.vcount_out <= '0;
      bus.hcount_out <= '0;
      bus.vsync_out  <= 1'b0;
      bus.vblnk_out  <= 1'b0;
      bus.hsync_out  <= 1'b0;
      bus.hblnk_out  <= 1'b0;
      bus.rgb_out    <= '0;
    end else begin
      bus.vcount_out <= s1.vcount;
      bus.hcount_out <= s1.hcount;
      bus.vsync_out  <= s1.vsync;
      bus.vblnk_out  <= s1.vblnk;
      bus.hsync_out  <= s1.hsync;
      bus.hblnk_out  <= s1.hblnk;
      bus.rgb_out    <= (hit && !blank) ? bar_colour(val_s1) : s1.rgb;
    end
  end
endmodule

// File: tb/tb_draw_bars.sv
// Scoreboard bench for draw_bars: a compressed frame scan over bar edges,
// gaps and key rows, with a behavioural buffer model producing expectations.
module tb_draw_bars;
  import vga_pkg::*;

  logic pclk = 1'b0;
  logic rst;
  always #5 pclk = ~pclk;

  draw_bars_if bus();
  draw_bars dut (.pclk(pclk), .rst(rst), .bus(bus));

  typedef struct {
    logic [11:0] rgb;
    logic [27:0] tim;
  } exp_t;

  exp_t               q[$];
  logic [11:0]        m_pend[N_CH];
  logic [11:0]        m_act[N_CH];
  logic               m_prev;
  logic               ld_req;
  logic [N_CH*12-1:0] ld_data;
  int                 n_tests = 0;
  int                 n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_rgb(input int h, input int v, input bit hb,
                                          input bit vb, input logic [11:0] bg);
    if (hb || vb) return bg;
    for (int i = 0; i < N_CH; i++) begin
      int l;
      int ht;
      l  = 24 + 76*i;
      ht = int'(m_act[i]) / 8;
      if (h >= l && h < l + 64 && ht > 0 && v <= 700 && v > 700 - ht) begin
        if (m_act[i] >= 12'd3072) return 12'hf00;
        if (m_act[i] >= 12'd2048) return 12'hff0;
        return 12'h0f0;
      end
    end
    return bg;
  endfunction

  task automatic pix(input int h, input int v, input bit hb, input bit vb);
    exp_t        e;
    logic        sw;
    logic        hs, vs;
    logic [11:0] bg;
    bg = 12'($urandom);
    hs = 1'($urandom);
    vs = 1'($urandom);
    bus.hcount_in   = 12'(h);
    bus.vcount_in   = 12'(v);
    bus.hblnk_in    = hb;
    bus.vblnk_in    = vb;
    bus.hsync_in    = hs;
    bus.vsync_in    = vs;
    bus.rgb_in      = bg;
    bus.ch_valid_in = ld_req;
    bus.ch_data_in  = ld_data;
    if (rst) begin
      q.delete();
      e.rgb = '0;
      e.tim = '0;
      q.push_back(e);
      q.push_back(e);
      sw = 1'b0;
      m_prev = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        m_pend[i] = '0;
        m_act[i]  = '0;
      end
    end else begin
      e.rgb = ref_rgb(h, v, hb, vb, bg);
      e.tim = {12'(v), 12'(h), vs, vb, hs, hb};
      q.push_back(e);
      sw = vb && !m_prev;
      if (sw) for (int i = 0; i < N_CH; i++) m_act[i] = m_pend[i];
      if (ld_req) for (int i = 0; i < N_CH; i++) m_pend[i] = ld_data[12*i +: 12];
      m_prev = vb;
    end
    ld_req = 1'b0;
    @(posedge pclk);
    #1;
    e = q.pop_front();
    chk("rgb", 32'(bus.rgb_out), 32'(e.rgb));
    chk("timing", 32'({bus.vcount_out, bus.hcount_out, bus.vsync_out,
                       bus.vblnk_out, bus.hsync_out, bus.hblnk_out}), 32'(e.tim));
    chk("upd", 32'(bus.upd_out), 32'(sw));
  endtask

  // load_row: row at which ch_valid fires (999 = on the vblnk rising edge).
  task automatic frame(input int load_row, input int rst_row);
    int rows[12] = '{0, 188, 189, 190, 300, 444, 445, 446, 699, 700, 701, 767};
    int offs[8]  = '{-1, 0, 1, 32, 63, 64, 70, 75};
    foreach (rows[r]) begin
      if (rows[r] == load_row) ld_req = 1'b1;
      if (rows[r] == rst_row) begin
        rst = 1'b1;
        pix(30, rows[r], 1'b0, 1'b0);
        pix(31, rows[r], 1'b0, 1'b0);
        rst = 1'b0;
      end
      for (int i = 0; i < N_CH; i++)
        foreach (offs[k]) pix(24 + 76*i + offs[k], rows[r], 1'b0, 1'b0);
      pix(30, rows[r], 1'b1, 1'b0);
      pix(410, rows[r], 1'b1, 1'b0);
    end
    if (load_row == 999) ld_req = 1'b1;
    pix(30, 700, 1'b0, 1'b1);
    pix(40, 700, 1'b1, 1'b1);
    for (int v = 768; v < 771; v++) pix(936, v, 1'b1, 1'b1);
  endtask

  initial begin
    rst     = 1'b1;
    ld_req  = 1'b0;
    ld_data = '0;
    repeat (3) pix(0, 0, 1'b0, 1'b0);
    rst = 1'b0;

    frame(-1, -1);
    frame(-1, -1);

    ld_data = '0;
    ld_data[0 +: 12]    = 12'hfff;
    ld_data[12*12 +: 12] = 12'h008;
    frame(300, -1);
    frame(-1, -1);

    ld_data = '0;
    ld_data[12*5 +: 12] = 12'd2048;
    frame(999, -1);
    frame(-1, -1);
    frame(-1, -1);

    ld_data = '0;
    ld_data[12*5 +: 12] = 12'd2047;
    ld_data[12*2 +: 12] = 12'd3072;
    ld_data[12*3 +: 12] = 12'd3071;
    ld_data[12*9 +: 12] = 12'd7;
    frame(0, -1);
    frame(-1, -1);

    frame(-1, 445);
    frame(-1, -1);
    frame(-1, -1);

    ld_data = '0;
    ld_data[0 +: 12] = 12'h800;
    frame(100, -1);
    frame(-1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
